// File: rtl/gf_merge_pkg.sv
// Shared definitions for the 4/5-from-5/5 fit merge block.
//   merge_state_e : FSM encoding (IDLE outside a group, GROUP while collecting)
//   SEL_FIRST     : expansion index that opens a group
//   SEL_LAST      : expansion index that closes a group
//   DROP_NONE     : drop-layer tag used for words that are not merged results
package gf_merge_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GROUP = 1'b1
    } merge_state_e;

    localparam logic [2:0] SEL_FIRST = 3'd1;
    localparam logic [2:0] SEL_LAST  = 3'd5;
    localparam logic [2:0] DROP_NONE = 3'd0;

endpackage

// File: rtl/chi2_best_keeper.sv
// Holds the best (lowest chi2) fit seen so far within one expansion group.
//   clock, reset      : clock and synchronous active-high reset
//   load              : start a new group with the presented fit
//   update            : candidate fit of the current group, kept if strictly better
//   chi2/payload/sel  : presented fit
//   best_*_next       : best fit including the presented one (what the
//                       registers will hold after this edge); lets the parent
//                       emit the winner in the same cycle the last fit is read
module chi2_best_keeper #(
    parameter int CHI2_W    = 16,
    parameter int PAYLOAD_W = 96
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 update,
    input  logic [CHI2_W-1:0]    chi2,
    input  logic [PAYLOAD_W-1:0] payload,
    input  logic [2:0]           sel,
    output logic [CHI2_W-1:0]    best_chi2_next,
    output logic [PAYLOAD_W-1:0] best_payload_next,
    output logic [2:0]           best_sel_next
);

    logic [CHI2_W-1:0]    best_chi2_r;
    logic [PAYLOAD_W-1:0] best_payload_r;
    logic [2:0]           best_sel_r;

    // Select the next best: load wins, else strict-less replace (ties keep the earlier fit)
    always_comb begin
        best_chi2_next    = best_chi2_r;
        best_payload_next = best_payload_r;
        best_sel_next     = best_sel_r;
        if (load || (update && (chi2 < best_chi2_r))) begin
            best_chi2_next    = chi2;
            best_payload_next = payload;
            best_sel_next     = sel;
        end else begin
            best_chi2_next    = best_chi2_r;
            best_payload_next = best_payload_r;
            best_sel_next     = best_sel_r;
        end
    end

    // Best-fit registers
    always_ff @(posedge clock) begin
        if (reset) begin
            best_chi2_r    <= {CHI2_W{1'b0}};
            best_payload_r <= {PAYLOAD_W{1'b0}};
            best_sel_r     <= 3'd0;
        end else begin
            best_chi2_r    <= best_chi2_next;
            best_payload_r <= best_payload_next;
            best_sel_r     <= best_sel_next;
        end
    end

endmodule

// File: rtl/fit_45_to_55_merge.sv
// Collapses groups of five expanded 4/5 fits (sel 1..5) back into one 5/5
// result carrying the lowest-chi2 fit and its dropped layer; genuine 4/5 fits
// and end-event words pass straight through, order preserved.
//   clock, reset        : clock, synchronous active-high reset
//   fifo_fit_*          : first-word-fall-through fit FIFO read side
//   out_hfull           : output FIFO half-full (gates reads only)
//   out_*               : registered output FIFO write side
//   seq_error/err_count : grouping-violation pulse and saturating counter
module fit_45_to_55_merge
    import gf_merge_pkg::*;
#(
    parameter int CHI2_W    = 16,
    parameter int PAYLOAD_W = 96,
    parameter int ERRCNT_W  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fifo_fit_empty,
    input  logic [CHI2_W-1:0]    fifo_fit_chi2,
    input  logic [PAYLOAD_W-1:0] fifo_fit_payload,
    input  logic [2:0]           fifo_fit_sel,
    input  logic                 fifo_fit_from55,
    input  logic                 fifo_fit_ee,
    output logic                 fifo_fit_re,
    input  logic                 out_hfull,
    output logic                 out_we,
    output logic [CHI2_W-1:0]    out_chi2,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [2:0]           out_drop_layer,
    output logic                 out_merged,
    output logic                 out_ee,
    output logic                 seq_error,
    output logic [ERRCNT_W-1:0]  err_count
);

    merge_state_e         state_r, state_s;
    logic [2:0]           exp_sel_r, exp_sel_s;
    logic                 rd_s, load_s, update_s;
    logic                 we_s, merged_s, ee_s, serr_s;
    logic [CHI2_W-1:0]    chi2_s, best_chi2_s;
    logic [PAYLOAD_W-1:0] payload_s, best_payload_s;
    logic [2:0]           drop_s, best_sel_s;
    logic [ERRCNT_W-1:0]  err_count_r;

    assign rd_s        = ~fifo_fit_empty & ~out_hfull;
    assign fifo_fit_re = rd_s;
    assign err_count   = err_count_r;

    chi2_best_keeper #(
        .CHI2_W    (CHI2_W),
        .PAYLOAD_W (PAYLOAD_W)
    ) u_keeper (
        .clock             (clock),
        .reset             (reset),
        .load              (load_s),
        .update            (update_s),
        .chi2              (fifo_fit_chi2),
        .payload           (fifo_fit_payload),
        .sel               (fifo_fit_sel),
        .best_chi2_next    (best_chi2_s),
        .best_payload_next (best_payload_s),
        .best_sel_next     (best_sel_s)
    );

    // Next-state, keeper control and next output word
    always_comb begin
        state_s   = state_r;
        exp_sel_s = exp_sel_r;
        load_s    = 1'b0;
        update_s  = 1'b0;
        we_s      = 1'b0;
        chi2_s    = {CHI2_W{1'b0}};
        payload_s = {PAYLOAD_W{1'b0}};
        drop_s    = DROP_NONE;
        merged_s  = 1'b0;
        ee_s      = 1'b0;
        serr_s    = 1'b0;
        if (rd_s) begin
            case (state_r)
                IDLE: begin
                    if (fifo_fit_ee || !fifo_fit_from55) begin
                        we_s      = 1'b1;
                        chi2_s    = fifo_fit_chi2;
                        payload_s = fifo_fit_payload;
                        ee_s      = fifo_fit_ee;
                    end else if (fifo_fit_sel == SEL_FIRST) begin
                        load_s    = 1'b1;
                        exp_sel_s = SEL_FIRST + 3'd1;
                        state_s   = GROUP;
                    end else begin
                        serr_s    = 1'b1;
                    end
                end
                GROUP: begin
                    if (fifo_fit_ee || !fifo_fit_from55) begin
                        // Group broken by a non-expanded word: drop group, keep word
                        serr_s    = 1'b1;
                        we_s      = 1'b1;
                        chi2_s    = fifo_fit_chi2;
                        payload_s = fifo_fit_payload;
                        ee_s      = fifo_fit_ee;
                        exp_sel_s = SEL_FIRST;
                        state_s   = IDLE;
                    end else if (fifo_fit_sel == exp_sel_r) begin
                        update_s = 1'b1;
                        if (fifo_fit_sel == SEL_LAST) begin
                            we_s      = 1'b1;
                            chi2_s    = best_chi2_s;
                            payload_s = best_payload_s;
                            drop_s    = best_sel_s;
                            merged_s  = 1'b1;
                            exp_sel_s = SEL_FIRST;
                            state_s   = IDLE;
                        end else begin
                            exp_sel_s = exp_sel_r + 3'd1;
                        end
                    end else if (fifo_fit_sel == SEL_FIRST) begin
                        // Out of order, but this word can open a fresh group
                        serr_s    = 1'b1;
                        load_s    = 1'b1;
                        exp_sel_s = SEL_FIRST + 3'd1;
                    end else begin
                        serr_s    = 1'b1;
                        exp_sel_s = SEL_FIRST;
                        state_s   = IDLE;
                    end
                end
                default: begin
                    exp_sel_s = SEL_FIRST;
                    state_s   = IDLE;
                end
            endcase
        end else begin
            state_s   = state_r;
            exp_sel_s = exp_sel_r;
        end
    end

    // FSM state and expected-index registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            exp_sel_r <= SEL_FIRST;
        end else begin
            state_r   <= state_s;
            exp_sel_r <= exp_sel_s;
        end
    end

    // Registered output word, error pulse and saturating error counter
    always_ff @(posedge clock) begin
        if (reset) begin
            out_we         <= 1'b0;
            out_chi2       <= {CHI2_W{1'b0}};
            out_payload    <= {PAYLOAD_W{1'b0}};
            out_drop_layer <= DROP_NONE;
            out_merged     <= 1'b0;
            out_ee         <= 1'b0;
            seq_error      <= 1'b0;
            err_count_r    <= {ERRCNT_W{1'b0}};
        end else begin
            out_we         <= we_s;
            out_chi2       <= chi2_s;
            out_payload    <= payload_s;
            out_drop_layer <= drop_s;
            out_merged     <= merged_s;
            out_ee         <= ee_s;
            seq_error      <= serr_s;
            if (serr_s && (err_count_r != {ERRCNT_W{1'b1}})) begin
                err_count_r <= err_count_r + {{(ERRCNT_W-1){1'b0}}, 1'b1};
            end else begin
                err_count_r <= err_count_r;
            end
        end
    end

endmodule

// File: tb/tb_fit_45_to_55_merge.sv
// Self-checking bench for fit_45_to_55_merge: directed scenarios plus a
// randomized stream, checked cycle by cycle against a group-list reference model.
module tb_fit_45_to_55_merge;

    localparam int CW = 16;
    localparam int PW = 96;
    localparam int EW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          fifo_fit_empty;
    logic [CW-1:0] fifo_fit_chi2;
    logic [PW-1:0] fifo_fit_payload;
    logic [2:0]    fifo_fit_sel;
    logic          fifo_fit_from55;
    logic          fifo_fit_ee;
    logic          fifo_fit_re;
    logic          out_hfull;
    logic          out_we;
    logic [CW-1:0] out_chi2;
    logic [PW-1:0] out_payload;
    logic [2:0]    out_drop_layer;
    logic          out_merged;
    logic          out_ee;
    logic          seq_error;
    logic [EW-1:0] err_count;

    fit_45_to_55_merge #(.CHI2_W(CW), .PAYLOAD_W(PW), .ERRCNT_W(EW)) dut (
        .clock(clock), .reset(reset),
        .fifo_fit_empty(fifo_fit_empty), .fifo_fit_chi2(fifo_fit_chi2),
        .fifo_fit_payload(fifo_fit_payload), .fifo_fit_sel(fifo_fit_sel),
        .fifo_fit_from55(fifo_fit_from55), .fifo_fit_ee(fifo_fit_ee),
        .fifo_fit_re(fifo_fit_re), .out_hfull(out_hfull),
        .out_we(out_we), .out_chi2(out_chi2), .out_payload(out_payload),
        .out_drop_layer(out_drop_layer), .out_merged(out_merged),
        .out_ee(out_ee), .seq_error(seq_error), .err_count(err_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [CW-1:0] chi2;
        logic [PW-1:0] payload;
        logic [2:0]    sel;
        logic          from55;
        logic          ee;
    } fit_t;

    typedef struct packed {
        logic          we;
        logic [CW-1:0] chi2;
        logic [PW-1:0] payload;
        logic [2:0]    drop;
        logic          merged;
        logic          ee;
        logic          serr;
    } out_t;

    int   checks = 0;
    int   errors = 0;
    fit_t grp[$];
    int   m_errs = 0;

    function automatic fit_t mk(int c, int s, bit f55, bit ee);
        fit_t w;
        w.chi2    = CW'(c);
        w.payload = {$urandom, $urandom, $urandom};
        w.sel     = 3'(s);
        w.from55  = f55;
        w.ee      = ee;
        return w;
    endfunction

    // Reference: the open group is a list; a merged result is its first minimum.
    function automatic out_t model_step(fit_t w);
        out_t o = '0;
        int   best;
        if (w.ee || !w.from55) begin
            if (grp.size() != 0) begin
                o.serr = 1'b1;
                grp.delete();
            end
            o.we = 1'b1; o.chi2 = w.chi2; o.payload = w.payload; o.ee = w.ee;
        end else if (grp.size() != 0 && int'(w.sel) == grp.size() + 1) begin
            grp.push_back(w);
            if (grp.size() == 5) begin
                best = 0;
                for (int i = 1; i < 5; i++)
                    if (grp[i].chi2 < grp[best].chi2) best = i;
                o.we = 1'b1; o.chi2 = grp[best].chi2; o.payload = grp[best].payload;
                o.drop = grp[best].sel; o.merged = 1'b1;
                grp.delete();
            end
        end else begin
            if (grp.size() != 0 || w.sel != 3'd1) o.serr = 1'b1;
            grp.delete();
            if (w.sel == 3'd1) grp.push_back(w);
        end
        if (o.serr && m_errs < 65535) m_errs++;
        return o;
    endfunction

    task automatic step(input fit_t w, input bit valid, input bit hf,
                        output bit re_seen, output out_t obs, output out_t exp);
        fifo_fit_empty   = !valid;
        fifo_fit_chi2    = w.chi2;
        fifo_fit_payload = w.payload;
        fifo_fit_sel     = w.sel;
        fifo_fit_from55  = w.from55;
        fifo_fit_ee      = w.ee;
        out_hfull        = hf;
        #1;
        re_seen = fifo_fit_re;
        @(posedge clock);
        #1;
        exp = (valid && !hf) ? model_step(w) : out_t'(0);
        obs = {out_we, out_chi2, out_payload, out_drop_layer, out_merged, out_ee, seq_error};
        if (!exp.we) begin
            obs.chi2 = '0; obs.payload = '0; obs.drop = '0; obs.merged = 1'b0; obs.ee = 1'b0;
        end
        fifo_fit_empty = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1; fifo_fit_empty = 1'b1; out_hfull = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        grp.delete();
        m_errs = 0;
    endtask

    task automatic test_reset();
        out_t obs;
        reset = 1'b1; fifo_fit_empty = 1'b0; out_hfull = 1'b0;
        fifo_fit_from55 = 1'b0; fifo_fit_ee = 1'b0; fifo_fit_sel = 3'd0;
        fifo_fit_chi2 = '0; fifo_fit_payload = '0;
        #1;
        checks++;
        if (fifo_fit_re !== 1'b1) begin
            errors++; $display("FAIL reset_re_open got=%b want=1", fifo_fit_re);
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
        obs = {out_we, out_chi2, out_payload, out_drop_layer, out_merged, out_ee, seq_error};
        checks++;
        if (obs !== out_t'(0) || err_count !== '0) begin
            errors++; $display("FAIL reset_outputs got=%h cnt=%0d want=0", obs, err_count);
        end
        out_hfull = 1'b1; #1;
        checks++;
        if (fifo_fit_re !== 1'b0) begin
            errors++; $display("FAIL reset_re_hfull got=%b want=0", fifo_fit_re);
        end
        do_reset();
    endtask

    task automatic test_pass_through();
        fit_t w[2]; out_t obs, exp; bit re;
        do_reset();
        w[0] = mk(100, 0, 1'b0, 1'b0);
        w[1] = mk(0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step(w[i], 1'b1, 1'b0, re, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL pass_model[%0d] got=%h want=%h", i, obs, exp);
            end
            checks++;
            if (!(out_we === 1'b1 && out_merged === 1'b0 && out_drop_layer === 3'd0 &&
                  out_ee === (i == 1) && out_payload === w[i].payload &&
                  (i == 1 || out_chi2 === 16'd100))) begin
                errors++; $display("FAIL pass_fields[%0d] we=%b ee=%b merged=%b drop=%0d chi2=%0d",
                                   i, out_we, out_ee, out_merged, out_drop_layer, out_chi2);
            end
        end
    endtask

    task automatic test_merge();
        int c[5] = '{50, 30, 40, 30, 60};
        fit_t w; out_t obs, exp; bit re;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            w = mk(c[i], i + 1, 1'b1, 1'b0);
            step(w, 1'b1, 1'b0, re, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL merge_model[%0d] got=%h want=%h", i, obs, exp);
            end
            checks++;
            if (i < 4 ? (out_we !== 1'b0)
                      : !(out_we === 1'b1 && out_chi2 === 16'd30 &&
                          out_drop_layer === 3'd2 && out_merged === 1'b1)) begin
                errors++; $display("FAIL merge_result[%0d] we=%b chi2=%0d drop=%0d merged=%b want chi2=30 drop=2",
                                   i, out_we, out_chi2, out_drop_layer, out_merged);
            end
        end
    endtask

    task automatic test_back_pressure();
        int c[5] = '{20, 9, 15, 12, 11};
        fit_t w; out_t obs, exp; bit re;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            w = mk(c[i], i + 1, 1'b1, 1'b0);
            if (i == 2) begin
                for (int k = 0; k < 10; k++) begin
                    step(w, 1'b1, 1'b1, re, obs, exp);
                    checks++;
                    if (re !== 1'b0 || out_we !== 1'b0 || seq_error !== 1'b0) begin
                        errors++; $display("FAIL stall[%0d] re=%b we=%b serr=%b want 0 0 0",
                                           k, re, out_we, seq_error);
                    end
                end
            end
            step(w, 1'b1, 1'b0, re, obs, exp);
            checks++;
            if (obs !== exp || re !== 1'b1) begin
                errors++; $display("FAIL bp_model[%0d] re=%b got=%h want=%h", i, re, obs, exp);
            end
        end
        checks++;
        if (!(out_we === 1'b1 && out_chi2 === 16'd9 && out_drop_layer === 3'd2)) begin
            errors++; $display("FAIL bp_result we=%b chi2=%0d drop=%0d want 1 9 2",
                               out_we, out_chi2, out_drop_layer);
        end
    endtask

    task automatic test_seq_errors();
        int s[3] = '{1, 2, 4};
        fit_t w; out_t obs, exp; bit re;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            w = mk(10 + i, s[i], 1'b1, 1'b0);
            step(w, 1'b1, 1'b0, re, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL seq_model[%0d] got=%h want=%h", i, obs, exp);
            end
        end
        checks++;
        if (!(seq_error === 1'b1 && out_we === 1'b0 && err_count === 16'd1)) begin
            errors++; $display("FAIL seq_skip serr=%b we=%b cnt=%0d want 1 0 1", seq_error, out_we, err_count);
        end
        step(mk(5, 1, 1'b1, 1'b0), 1'b1, 1'b0, re, obs, exp);
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL seq_open got=%h want=%h", obs, exp);
        end
        w = mk(0, 0, 1'b0, 1'b1);
        step(w, 1'b1, 1'b0, re, obs, exp);
        checks++;
        if (!(seq_error === 1'b1 && out_we === 1'b1 && out_ee === 1'b1 &&
              out_payload === w.payload && err_count === 16'd2)) begin
            errors++; $display("FAIL seq_ee serr=%b we=%b ee=%b cnt=%0d want 1 1 1 2",
                               seq_error, out_we, out_ee, err_count);
        end
    endtask

    task automatic test_reset_mid_group();
        int c[5] = '{20, 21, 22, 23, 7};
        fit_t w; out_t obs, exp; bit re; int writes = 0;
        do_reset();
        for (int i = 0; i < 3; i++) step(mk(3, i + 1, 1'b1, 1'b0), 1'b1, 1'b0, re, obs, exp);
        do_reset();
        checks++;
        if (out_we !== 1'b0 || seq_error !== 1'b0 || err_count !== '0) begin
            errors++; $display("FAIL midreset_quiet we=%b serr=%b cnt=%0d want 0 0 0", out_we, seq_error, err_count);
        end
        for (int i = 0; i < 5; i++) begin
            w = mk(c[i], i + 1, 1'b1, 1'b0);
            step(w, 1'b1, 1'b0, re, obs, exp);
            if (out_we === 1'b1) writes++;
        end
        checks++;
        if (!(writes == 1 && out_we === 1'b1 && out_chi2 === 16'd7 && out_drop_layer === 3'd5 &&
              seq_error === 1'b0 && err_count === '0)) begin
            errors++; $display("FAIL midreset_group writes=%0d chi2=%0d drop=%0d cnt=%0d want 1 7 5 0",
                               writes, out_chi2, out_drop_layer, err_count);
        end
    endtask

    task automatic test_random();
        fit_t w; out_t obs, exp; bit re, valid, hf, need = 1'b1;
        int gen_sel = 1; int r;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (need) begin
                r = $urandom_range(0, 19);
                if (r == 0)      w = mk($urandom_range(0, 15), 0, 1'b0, 1'b1);
                else if (r == 1) w = mk($urandom_range(0, 15), 0, 1'b0, 1'b0);
                else if (r == 2) w = mk($urandom_range(0, 15), $urandom_range(0, 7), 1'b1, 1'b0);
                else begin
                    w = mk($urandom_range(0, 15), gen_sel, 1'b1, 1'b0);
                    gen_sel = (gen_sel == 5) ? 1 : gen_sel + 1;
                end
            end
            valid = ($urandom_range(0, 3) != 0);
            hf    = ($urandom_range(0, 4) == 0);
            step(w, valid, hf, re, obs, exp);
            need = valid && !hf;
            checks++;
            if (re !== (valid && !hf)) begin
                errors++; $display("FAIL rand_re[%0d] got=%b want=%b", n, re, valid && !hf);
            end
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL rand_out[%0d] got=%h want=%h", n, obs, exp);
            end
            checks++;
            if (err_count !== EW'(m_errs)) begin
                errors++; $display("FAIL rand_errcnt[%0d] got=%0d want=%0d", n, err_count, m_errs);
            end
        end
    endtask

    initial begin
        reset = 1'b1; fifo_fit_empty = 1'b1; out_hfull = 1'b0;
        fifo_fit_chi2 = '0; fifo_fit_payload = '0; fifo_fit_sel = 3'd0;
        fifo_fit_from55 = 1'b0; fifo_fit_ee = 1'b0;
        test_reset();
        test_pass_through();
        test_merge();
        test_back_pressure();
        test_seq_errors();
        test_reset_mid_group();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fit_45_to_55_merge.md
# fit_45_to_55_merge

Sits downstream of the track fitter, at the far end of the 5/5→4/5 combination expansion. It reads fit results from the fit FIFO and passes genuine 4/5 fits and end-event words straight through. Each group of five 4/5 fits that came from one expanded 5/5 combination collapses back into a single result: the fit with the lowest chi2, tagged with the layer that was dropped. The results go to the output FIFO in the same order they arrived.

## Interface
- CHI2_W, 16, chi2 width (unsigned)
- PAYLOAD_W, 96, opaque fit payload width (track parameters, road id)
- ERRCNT_W, 16, sequence-error counter width
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- fifo_fit_empty  in  1  fit FIFO empty; first-word-fall-through, so fields are valid whenever not empty
- fifo_fit_chi2  in  CHI2_W  fit chi2
- fifo_fit_payload  in  PAYLOAD_W  fit payload
- fifo_fit_sel  in  3  expansion index 1..5 (layer dropped); 0 is illegal for expanded words
- fifo_fit_from55  in  1  fit originated from 5/5 expansion
- fifo_fit_ee  in  1  end-event word; other fields are don't-care except payload, which carries the event tag
- fifo_fit_re  out  1  read strobe
- out_hfull  in  1  output FIFO half-full
- out_we  out  1  output write strobe
- out_chi2  out  CHI2_W  chi2 of emitted word
- out_payload  out  PAYLOAD_W  payload of emitted word
- out_drop_layer  out  3  sel of the winning fit for a merged group; 0 for pass-through and ee
- out_merged  out  1  word is a merged 5/5 result
- out_ee  out  1  end-event word
- seq_error  out  1  one-cycle pulse on a grouping violation
- err_count  out  ERRCNT_W  saturating count of seq_error pulses

## Operation
- fifo_fit_re = ~fifo_fit_empty & ~out_hfull, in every state. No bubbles.
- FSM has two states, IDLE and GROUP, plus a 3-bit expected-index counter `exp_sel` and best registers `best_chi2`, `best_payload`, `best_sel`.
- IDLE, on a read:
  - ee or from55=0: write through.
  - from55=1 with sel=1: load best_* from the word, set exp_sel=2, go to GROUP.
  - from55=1 with sel≠1: pulse seq_error, discard the word, stay in IDLE.
- GROUP, on a read:
  - from55=1 with sel==exp_sel: if fifo_fit_chi2 < best_chi2 (strict; ties keep the earlier fit), replace best_*.
  - If that sel was 5: emit best (out_merged=1, out_drop_layer=best_sel), go to IDLE. Otherwise increment exp_sel.
  - from55=1 with sel≠exp_sel: pulse seq_error, discard the group. If sel==1, start a new group with this word (exp_sel=2, stay in GROUP); otherwise discard the word and go to IDLE.
  - from55=0 or ee: pulse seq_error, discard the group, write the word through, go to IDLE.
- At most one output write per cycle in every case.
- err_count increments on each seq_error and saturates at its maximum value.
- Comparison is unsigned over the full CHI2_W. No rounding.

## Timing
- Every output is registered. A word read in cycle N is written in cycle N+1 (out_we high for exactly one cycle).
- A merged result is written in the cycle after its sel=5 word is read.
- seq_error is registered with the same one-cycle latency as the read that causes it.
- out_hfull gates reads only. At most one write can land after out_hfull rises; the half-full margin absorbs it.
- Reset values: state=IDLE, exp_sel=1, best_*=0, fifo_fit_re follows the combinational formula, out_we=0, all out_* data=0, seq_error=0, err_count=0.
- Reset in the middle of a group drops the partial group silently: no emit and no seq_error.
- A stall (empty or hfull) in the middle of a group holds all state. No timeout.

## Structure
- Package gf_merge_pkg holds:
  - state encodings IDLE=1'b0, GROUP=1'b1
  - SEL_FIRST=3'd1, SEL_LAST=3'd5, DROP_NONE=3'd0
- One natural sub-module, chi2_best_keeper. Its inputs are load, update-enable, chi2, payload and sel. It owns the best_* registers and the strict-less compare.

## Test plan
- Pass-through: from55=0 fit (chi2=100), then an ee word → two writes in consecutive cycles, out_merged=0, out_drop_layer=0, second write has out_ee=1.
- Merge: five from55 fits, sel 1..5, chi2 = 50, 30, 40, 30, 60 → one write with out_chi2=30, out_drop_layer=2, out_merged=1, one cycle after the sel=5 read.
- Back-pressure: hold out_hfull=1 for 10 cycles in the middle of a group → fifo_fit_re=0 throughout, and the result is unchanged once the stall is released.
- Sequence errors:
  - sel 1, 2, then 4 → seq_error pulses, no write, err_count=1.
  - sel 1, then ee → seq_error, the ee is written, err_count=2.
- Reset after sel=3 of a group, then a fresh group sel 1..5 with chi2=7 on sel=5 → exactly one write, chi2=7, drop_layer=5, err_count=0.
